// File: rtl/div_pkg.sv
// Shared types and defaults for the divided-clock checker.
package div_pkg;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } div_chk_state_t;
endpackage

// File: rtl/div_edge_det.sv
// Edge detector for the monitored divided signal.
// Defining DIV_CHECKER_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module div_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic div_in,
  output logic div_edge
);
  logic div_s;
  logic div_d;

`ifdef DIV_CHECKER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], div_in};
  end

  assign div_s = sync_q[1];
`else
  assign div_s = div_in;
`endif

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div_d <= 1'b0;
    else       div_d <= div_s;
  end

  assign div_edge = div_s ^ div_d;
endmodule

// File: rtl/div_checker.sv
// Frequency/phase monitor for a divided signal in the clk domain: measures
// edge-to-edge intervals and reports lock and errors. See DIV_CHECKER_SYNC_EN.
module div_checker
  import div_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_half,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] meas_half
);
  localparam int               MATCH_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);

  div_chk_state_t     state;
  logic [CNT_W-1:0]   cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic               div_edge;
  logic               exp_valid;
  logic               at_exp;
  logic               checking;
  logic               err_now;

  div_edge_det u_edge_det (
    .clk      (clk),
    .rstn     (rstn),
    .div_in   (div_in),
    .div_edge (div_edge)
  );

  // An error is a mismatching edge or, without an edge, the interval running out.
  // NOTE: continuous assigns here cannot infer latches, unlike an incomplete always_comb.
  assign exp_valid = enable && (exp_half != '0);
  assign at_exp    = (cnt == exp_half);
  assign checking  = exp_valid && ((state == MEASURE) || (state == LOCKED));
  assign err_now   = checking && (div_edge ? !at_exp : at_exp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse  <= err_now;
      err_sticky <= err_now | (err_sticky & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!exp_valid || state == IDLE) begin
      cnt <= '0;
    end else if (div_edge) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      match_cnt <= '0;
      locked    <= 1'b0;
      meas_half <= '0;
    end else if (!exp_valid) begin
      state  <= IDLE;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= SYNC;

        SYNC: begin
          if (div_edge) begin
            match_cnt <= '0;
            state     <= MEASURE;
          end
        end

        MEASURE: begin
          if (div_edge) begin
            meas_half <= cnt;
            if (at_exp) begin
              match_cnt <= match_cnt + MATCH_W'(1);
              if (match_cnt == LOCK_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end else if (at_exp) begin
            state <= SYNC;
          end
        end

        LOCKED: begin
          if (div_edge) begin
            meas_half <= cnt;
            if (!at_exp) begin
              match_cnt <= '0;
              state     <= MEASURE;
              locked    <= 1'b0;
            end
          end else if (at_exp) begin
            state  <= SYNC;
            locked <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/div_checker.md
# div_checker

Frequency and phase monitor for a divided-clock signal generated inside the `clk` domain, such as the toggle output of the team's divide-by-2 divider. It detects every edge of `div_in` and measures the interval between edges in `clk` cycles. It compares each interval against a programmed expected half-period and reports lock, per-event errors, a sticky error flag and the last measured interval. It sits beside the divider on the consumer side and serves as the self-check for divider outputs.

## Interface
- `CNT_W`, default 8: width of the interval counter, `exp_half` and `meas_half`.
- `LOCK_CNT`, default 4: consecutive matching intervals required to declare lock (≥1).
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enable` in 1: monitoring enable, level-sensitive.
- `div_in` in 1: monitored divided signal, synchronous to `clk` unless `DIV_CHECKER_SYNC_EN` is defined.
- `exp_half` in CNT_W: expected cycles between consecutive edges; 0 = invalid.
- `err_clr` in 1: single-cycle clear of `err_sticky`.
- `locked` out 1: lock status.
- `err_pulse` out 1: one-cycle error strobe.
- `err_sticky` out 1: latched error flag.
- `meas_half` out CNT_W: last measured edge-to-edge interval, saturating.

## Operation
- **Edge detect:** `div_d` registers `div_in` every cycle, in all states. `edge = div_in ^ div_d`.
- **Interval counter `cnt`:**
  - Set to 1 on an edge cycle.
  - Incremented each cycle otherwise, saturating at 2^CNT_W−1.
  - Cleared in IDLE.
  - On an edge, the pre-update `cnt` is the interval. Example: a toggle-every-cycle input gives interval 1.
- **IDLE:** entered when `enable`=0 or `exp_half`=0. Leaves to SYNC when `enable`=1 and `exp_half`≠0.
- **SYNC:** waits for the first edge. No comparison is made. On that edge: `cnt`←1, `match_cnt`←0, go to MEASURE.
- **MEASURE:** on each edge:
  - `meas_half`←`cnt`.
  - Match (`cnt`==`exp_half`): `match_cnt`++. When `match_cnt` reaches LOCK_CNT, go to LOCKED.
  - Mismatch: `match_cnt`←0 and raise error.
- **LOCKED:** `locked`=1. On each edge, `meas_half`←`cnt`. On a mismatch: raise error and go to MEASURE with `match_cnt`=0.
- **Late edge (MEASURE/LOCKED):** no edge while `cnt`==`exp_half` raises an error and goes to SYNC.
- **Raise error:** `err_pulse`=1 for one cycle and `err_sticky`←1.
- **err_clr:** clears `err_sticky`. A new error in the same cycle wins, so `err_sticky` stays 1.
- **Leaving for IDLE:** dropping `enable`, or `exp_half`→0, in any state goes to IDLE next cycle with `locked`=0. `err_sticky` and `meas_half` are retained.
- **Changing `exp_half`:** a change while enabled applies to the next comparison. No restart is forced.
- **Saturation:** a saturated `cnt` never equals a valid `exp_half` unless `exp_half` is all-ones. That case is still handled by the late-edge rule.

## Timing
- **Reset values:** `locked`=0, `err_pulse`=0, `err_sticky`=0, `meas_half`=0, state IDLE, `div_d`=0, `cnt`=0, `match_cnt`=0.
- All outputs are registered.
- `err_pulse` and the `meas_half` update appear one cycle after the offending or measured edge cycle.
- `locked` rises one cycle after the LOCK_CNT-th matching edge. It falls one cycle after the mismatching edge, late detection or disable.
- An edge and a late condition cannot coincide; an edge takes priority by definition.
- Minimum measurable interval: 1 cycle.

## Configuration
- `DIV_CHECKER_SYNC_EN` defined: `div_in` passes through a 2-flop synchronizer, reset to 0, before edge detection. This adds 2 cycles to all output latencies; intervals are unchanged.
- Undefined: `div_in` feeds the edge detector directly.

## Structure
- **Package `div_pkg`:**
  - state enum typedef `div_chk_state_t` (IDLE, SYNC, MEASURE, LOCKED);
  - default `CNT_W` constant;
  - default `LOCK_CNT` constant.
- **Sub-module `div_edge_det`:** optional synchronizer plus `div_d` register; outputs `edge`.
- The FSM, counters and outputs live in the top module.

## Test plan
- `exp_half`=1, `div_in` toggling every cycle, LOCK_CNT=4 → `locked`=1 one cycle after the 5th edge (1 SYNC edge + 4 matches). `meas_half`=1, no errors.
- `exp_half`=3, `div_in` period 6 until locked, then one 2-cycle interval → `err_pulse` one cycle, `err_sticky`=1, `locked`=0, `meas_half`=2. Relock after 4 further matching edges.
- Locked at `exp_half`=3, `div_in` held constant → `err_pulse` one cycle after `cnt` reaches 3 without an edge, state SYNC, `locked`=0.
- `err_sticky`=1, `err_clr` pulsed alone → 0 next cycle. `err_clr` coincident with a mismatch edge → stays 1.
- `rstn` asserted mid-LOCKED → all outputs 0 immediately, without a clock edge.
- `enable`→0 while locked → IDLE, `locked`=0 next cycle, `err_sticky` retained. `enable`=1 with `exp_half`=0 → remains IDLE.
